motor_drive_ctrl: RTL and testbench

Successor to the car's fixed command-to-bridge decoder. Takes a 3-bit drive command plus a speed value and drives two H-bridges (left and right wheel) through motor[3:0]. Adds PWM speed control, a dead-time interval on every direction reversal, and a command watchdog that stops the car when commands stop arriving. Sits between the IR/remote command decoder and the motor driver pins.

---
 rtl/motor_drive_pkg.sv | 30 +++
 rtl/motor_bridge_fsm.sv | 84 ++++++++
 rtl/motor_drive_ctrl.sv | 129 ++++++++++++
 tb/tb_motor_drive_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_pkg.sv
// motor_drive_pkg
// Shared definitions for the motor drive controller. It holds the drive
// command codes, the per-wheel direction request type, the wheel FSM state
// type, and a helper that folds the unused command codes onto stop.
package motor_drive_pkg;

    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_FWD   = 3'd1;
    localparam logic [2:0] CMD_REV   = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        DIR_OFF = 2'd0,
        DIR_FWD = 2'd1,
        DIR_REV = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } wheel_st_e;

    // Codes 5..7 have no meaning and are stored as stop.
    function automatic logic [2:0] sanitize_cmd(input logic [2:0] c);
        return (c > CMD_RIGHT) ? CMD_STOP : c;
    endfunction

endpackage

// File: rtl/motor_bridge_fsm.sv
// motor_bridge_fsm
// Controls one H-bridge. It follows the requested direction and inserts a
// dead interval, with both inputs low, whenever the direction reverses.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          requested direction (off / forward / reverse)
//   pwm_on       PWM gate for the current cycle
//   fwd, rev     registered bridge inputs
//   dead_active  high while the bridge is in its dead interval
module motor_bridge_fsm
    import motor_drive_pkg::*;
#(
    parameter int DEAD_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  dir_e req,
    input  logic pwm_on,
    output logic fwd,
    output logic rev,
    output logic dead_active
);

    localparam int CNT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    wheel_st_e        state;
    dir_e             dir_q;
    logic [CNT_W-1:0] dead_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            dir_q    <= DIR_OFF;
            dead_cnt <= '0;
            fwd      <= 1'b0;
            rev      <= 1'b0;
        end else begin
            // The outputs follow the state of the previous cycle. Because dir_q
            // holds a single direction, fwd and rev can never both be high.
            fwd <= (state == ST_DRIVE) && (dir_q == DIR_FWD) && pwm_on;
            rev <= (state == ST_DRIVE) && (dir_q == DIR_REV) && pwm_on;

            case (state)
                ST_OFF: begin
                    if (req != DIR_OFF) begin
                        state <= ST_DRIVE;
                        dir_q <= req;
                    end
                end
                ST_DRIVE: begin
                    if (req == DIR_OFF) begin
                        state <= ST_OFF;
                        dir_q <= DIR_OFF;
                    end else if (req != dir_q) begin
                        state    <= ST_DEAD;
                        dead_cnt <= CNT_W'(DEAD_CYC - 1);
                    end
                end
                ST_DEAD: begin
                    // The dead interval always runs its full length. The request
                    // is only sampled on the exit cycle.
                    if (dead_cnt == '0) begin
                        if (req == DIR_OFF) begin
                            state <= ST_OFF;
                            dir_q <= DIR_OFF;
                        end else begin
                            state <= ST_DRIVE;
                            dir_q <= req;
                        end
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    dir_q <= DIR_OFF;
                end
            endcase
        end
    end

    assign dead_active = (state == ST_DEAD);

endmodule

// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl
// Turns remote drive commands into H-bridge drive for two wheels. It adds
// PWM speed control, dead time on direction reversal, and a command watchdog.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_valid    strobe; cmd and speed are sampled while it is high
//   cmd          0 stop, 1 fwd, 2 rev, 3 left, 4 right, 5..7 stop
//   speed        duty request; all-ones means always on
//   motor        {IN4,IN3,IN2,IN1}; A = {IN2 rev, IN1 fwd}, B = {IN3 rev, IN4 fwd}
//   dead_active  bit0 wheel A, bit1 wheel B in dead time
//   timeout      watchdog expired, both wheels forced off
module motor_drive_ctrl
    import motor_drive_pkg::*;
#(
    parameter int PWM_W       = 8,
    parameter int DEAD_CYC    = 1000,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [PWM_W-1:0] speed,
    output logic [3:0]       motor,
    output logic [1:0]       dead_active,
    output logic             timeout
);

    logic [2:0]       cmd_reg;
    logic [PWM_W-1:0] speed_reg;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;
    logic             timeout_r;
    dir_e             req_a;
    dir_e             req_b;
    logic             a_fwd, a_rev, b_fwd, b_rev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg   <= CMD_STOP;
            speed_reg <= '0;
        end else if (cmd_valid) begin
            cmd_reg   <= sanitize_cmd(cmd);
            speed_reg <= speed;
        end
    end

    // The duty only changes at the counter wrap, so a PWM period never mixes
    // two duty values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                duty <= speed_reg;
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty) || (duty == '1);

    generate
        if (TIMEOUT_CYC > 0) begin : g_wd
            localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
            localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

            logic [WD_W-1:0] wd_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cnt    <= '0;
                    timeout_r <= 1'b0;
                end else if (cmd_valid) begin
                    // A command that arrives on the expiry cycle takes priority.
                    wd_cnt    <= '0;
                    timeout_r <= 1'b0;
                end else if (wd_cnt != WD_MAX) begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (wd_cnt + 1'b1 == WD_MAX) begin
                        timeout_r <= 1'b1;
                    end
                end
            end
        end else begin : g_no_wd
            assign timeout_r = 1'b0;
        end
    endgenerate

    always_comb begin
        req_a = DIR_OFF;
        req_b = DIR_OFF;
        if (!timeout_r) begin
            case (cmd_reg)
                CMD_FWD:   begin req_a = DIR_FWD; req_b = DIR_FWD; end
                CMD_REV:   begin req_a = DIR_REV; req_b = DIR_REV; end
                CMD_LEFT:  begin req_a = DIR_FWD; req_b = DIR_OFF; end
                CMD_RIGHT: begin req_a = DIR_OFF; req_b = DIR_FWD; end
                default:   begin req_a = DIR_OFF; req_b = DIR_OFF; end
            endcase
        end
    end

    motor_bridge_fsm #(.DEAD_CYC(DEAD_CYC)) u_wheel_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_a),
        .pwm_on      (pwm_on),
        .fwd         (a_fwd),
        .rev         (a_rev),
        .dead_active (dead_active[0])
    );

    motor_bridge_fsm #(.DEAD_CYC(DEAD_CYC)) u_wheel_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_b),
        .pwm_on      (pwm_on),
        .fwd         (b_fwd),
        .rev         (b_rev),
        .dead_active (dead_active[1])
    );

    assign motor   = {b_fwd, b_rev, a_rev, a_fwd};
    assign timeout = timeout_r;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl
// Self-checking bench for motor_drive_ctrl with PWM_W=4, DEAD_CYC=4 and
// TIMEOUT_CYC=100. A behavioural model written with integer counters
// predicts motor, dead_active and timeout for every cycle. Directed
// sequences pin latency, dead time, PWM ratio, watchdog and reset behaviour.
// A randomized phase follows the directed sequences.
module tb_motor_drive_ctrl;

    localparam int PWM_W = 4;
    localparam int DEAD  = 4;
    localparam int TMO   = 100;
    localparam int PMAX  = (1 << PWM_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [PWM_W-1:0] speed;
    logic [3:0]       motor;
    logic [1:0]       dead_active;
    logic             timeout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    motor_drive_ctrl #(.PWM_W(PWM_W), .DEAD_CYC(DEAD), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .speed       (speed),
        .motor       (motor),
        .dead_active (dead_active),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model. Each wheel has a drive direction (0 off, 1 fwd,
    // 2 rev) and a count of dead cycles still to run (0 = not in dead time).
    int         m_cmd, m_spd, m_duty, m_cnt, m_idle;
    bit         m_to;
    int         m_d[2];
    int         m_dl[2];
    logic [3:0] m_motor;
    int         r[2];
    bit         on;

    function automatic int req_of(input int c, input bit to, input int w);
        if (to) return 0;
        case (c)
            1: return 1;
            2: return 2;
            3: return (w == 0) ? 1 : 0;
            4: return (w == 1) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd = 0; m_spd = 0; m_duty = 0; m_cnt = 0; m_idle = 0; m_to = 0;
            m_d[0] = 0; m_d[1] = 0; m_dl[0] = 0; m_dl[1] = 0; m_motor = 4'b0;
        end else begin
            r[0] = req_of(m_cmd, m_to, 0);
            r[1] = req_of(m_cmd, m_to, 1);
            on   = (m_cnt < m_duty) || (m_duty == PMAX);
            m_motor[0] = (m_dl[0] == 0) && (m_d[0] == 1) && on;
            m_motor[1] = (m_dl[0] == 0) && (m_d[0] == 2) && on;
            m_motor[3] = (m_dl[1] == 0) && (m_d[1] == 1) && on;
            m_motor[2] = (m_dl[1] == 0) && (m_d[1] == 2) && on;
            for (int w = 0; w < 2; w++) begin
                if (m_dl[w] > 0) begin
                    m_dl[w] = m_dl[w] - 1;
                    if (m_dl[w] == 0) m_d[w] = r[w];
                end else if (m_d[w] == 0 || r[w] == 0) begin
                    m_d[w] = r[w];
                end else if (r[w] != m_d[w]) begin
                    m_dl[w] = DEAD;
                    m_d[w]  = 0;
                end
            end
            if (m_cnt == PMAX) m_duty = m_spd;
            m_cnt = (m_cnt + 1) % (PMAX + 1);
            if (cmd_valid) begin
                m_cmd = (cmd > 3'd4) ? 0 : int'(cmd);
                m_spd = int'(speed);
                m_idle = 0;
                m_to = 0;
            end else if (m_idle < TMO) begin
                m_idle++;
                if (m_idle == TMO) m_to = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (motor !== m_motor) begin
                errors++;
                $display("FAIL motor t=%0t actual=%b expected=%b", $time, motor, m_motor);
            end
            checks++;
            if (dead_active !== {m_dl[1] > 0, m_dl[0] > 0}) begin
                errors++;
                $display("FAIL dead_active t=%0t actual=%b expected=%b", $time, dead_active,
                         {m_dl[1] > 0, m_dl[0] > 0});
            end
            checks++;
            if (timeout !== m_to) begin
                errors++;
                $display("FAIL timeout t=%0t actual=%b expected=%b", $time, timeout, m_to);
            end
            checks++;
            if ((motor[0] & motor[1]) | (motor[2] & motor[3])) begin
                errors++;
                $display("FAIL shoot_through t=%0t actual=%b required=no fwd&rev", $time, motor);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [PWM_W-1:0] s);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        speed     = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int zc, dc, hi, lo, k;
        bit saw_dead;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; speed = '0;
        repeat (3) @(negedge clk);
        check("reset_motor", 32'(motor), 32'h0);
        check("reset_dead", 32'(dead_active), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Load full duty, then check the forward latency.
        send(3'd0, 4'hF);
        repeat (20) @(negedge clk);
        send(3'd1, 4'hF);
        @(negedge clk);
        check("fwd_lat_e1", 32'(motor), 32'h0);
        @(negedge clk);
        check("fwd_lat_e2", 32'(motor), 32'b1001);
        check("fwd_dead", 32'(dead_active), 32'h0);

        // Reversal: four all-low cycles, four dead cycles, then reverse.
        send(3'd2, 4'hF);
        zc = 0; dc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (motor == 4'b0) zc++;
            if (dead_active == 2'b11) dc++;
        end
        check("rev_zero_cycles", 32'(zc), 32'd4);
        check("rev_dead_cycles", 32'(dc), 32'd4);
        check("rev_motor", 32'(motor), 32'b0110);

        // Left turn at speed 4: IN1 high 4 of every 16 cycles.
        send(3'd3, 4'd4);
        repeat (20) @(negedge clk);
        hi = 0; lo = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (motor[0]) hi++;
            if (motor[3:1] != 3'b0) lo++;
        end
        check("left_in1_high", 32'(hi), 32'd8);
        check("left_others", 32'(lo), 32'd0);
        send(3'd3, 4'd0);
        repeat (20) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (motor[0]) hi++;
        end
        check("left_speed0", 32'(hi), 32'd0);

        // Watchdog.
        send(3'd4, 4'hF);
        repeat (20) @(negedge clk);
        check("right_motor", 32'(motor), 32'b1000);
        k = 20;
        while (timeout !== 1'b1 && k < 150) begin
            @(negedge clk);
            k++;
        end
        check("wd_expiry_cycle", 32'(k), 32'd100);
        repeat (2) @(negedge clk);
        check("wd_motor_off", 32'(motor), 32'h0);
        send(3'd4, 4'hF);
        check("wd_cleared", 32'(timeout), 32'h0);
        repeat (2) @(negedge clk);
        check("wd_restore", 32'(motor), 32'b1000);

        // Invalid codes act as stop.
        send(3'd5, 4'hF);
        repeat (4) @(negedge clk);
        check("cmd5_stop", 32'(motor), 32'h0);
        send(3'd7, 4'hF);
        repeat (4) @(negedge clk);
        check("cmd7_stop", 32'(motor), 32'h0);

        // Reset in the middle of a dead interval.
        send(3'd1, 4'hF);
        repeat (3) @(negedge clk);
        check("pre_rst_fwd", 32'(motor), 32'b1001);
        send(3'd2, 4'hF);
        repeat (2) @(negedge clk);
        check("pre_rst_dead", 32'(dead_active), 32'b11);
        #1 rst_n = 1'b0;
        #1;
        check("rst_motor", 32'(motor), 32'h0);
        check("rst_dead", 32'(dead_active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(3'd2, 4'hF);
        k = 0; saw_dead = 1'b0;
        while (motor !== 4'b0110 && k < 60) begin
            @(negedge clk);
            if (dead_active != 2'b0) saw_dead = 1'b1;
            k++;
        end
        check("post_rst_rev", 32'(motor), 32'b0110);
        check("post_rst_no_dead", 32'(saw_dead), 32'h0);

        // Randomized traffic, with gaps long enough to sometimes trip the watchdog.
        for (int seg = 0; seg < 40; seg++) begin
            repeat ($urandom_range(0, 120)) @(negedge clk);
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
        repeat (30) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
